// File: rtl/reaction_timer_pkg.sv
// Shared game definitions: timer state encoding, counter sizing and the game-level
// state codes driven to the countdown block.
package reaction_timer_pkg;

    localparam int unsigned CNT_W     = 14;
    localparam int unsigned MAX_COUNT = 9999;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StArmed  = 2'd1,
        StTiming = 2'd2,
        StDone   = 2'd3
    } rt_state_e;

    typedef enum logic [1:0] {
        GameIdle  = 2'd0,
        GameDelay = 2'd1,
        GameReact = 2'd2,
        GameShow  = 2'd3
    } game_state_e;

    // Strictly lower wins; an equal time leaves the stored best untouched.
    function automatic logic beats_best(input int unsigned cand, input int unsigned cur,
                                        input logic cur_valid);
        return !cur_valid || (cand < cur);
    endfunction

endpackage

// File: rtl/reaction_timer_button_sync.sv
// Two-flop synchronizer for an asynchronous button, followed by a rising-edge detector
// that yields a single-cycle press pulse however long the button is held.
module reaction_timer_button_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic btn,
    output logic press
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    assign press = sync2_q & ~prev_q;

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: counts 1 ms ticks from the stimulus (go) to the player's press, flags
// false starts and timeouts, and keeps the best valid time since reset.
module reaction_timer #(
    parameter int unsigned CNT_W     = reaction_timer_pkg::CNT_W,
    parameter int unsigned MAX_COUNT = reaction_timer_pkg::MAX_COUNT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             arm,
    input  logic             go,
    input  logic             button,
    output logic [CNT_W-1:0] elapsed,
    output logic             result_valid,
    output logic             false_start,
    output logic             timeout,
    output logic [CNT_W-1:0] best,
    output logic             best_valid,
    output logic             busy
);

    import reaction_timer_pkg::*;

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_COUNT);

    rt_state_e        state_q, state_d;
    logic [CNT_W-1:0] elapsed_q, elapsed_d;
    logic [CNT_W-1:0] best_q, best_d;
    logic             result_valid_q, result_valid_d;
    logic             false_start_q, false_start_d;
    logic             timeout_q, timeout_d;
    logic             best_valid_q, best_valid_d;
    logic             press;
    logic             at_max;

    reaction_timer_button_sync u_button_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .btn     (button),
        .press   (press)
    );

    assign at_max = (elapsed_q == MaxCnt);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            elapsed_q      <= '0;
            best_q         <= '0;
            result_valid_q <= 1'b0;
            false_start_q  <= 1'b0;
            timeout_q      <= 1'b0;
            best_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            elapsed_q      <= elapsed_d;
            best_q         <= best_d;
            result_valid_q <= result_valid_d;
            false_start_q  <= false_start_d;
            timeout_q      <= timeout_d;
            best_valid_q   <= best_valid_d;
        end
    end

    // Priority in both active states: press first, then go/timeout, then arm drop.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (arm) state_d = StArmed;
            StArmed: begin
                if (press)     state_d = StDone;
                else if (go)   state_d = StTiming;
                else if (!arm) state_d = StIdle;
            end
            StTiming: begin
                if (press || at_max) state_d = StDone;
                else if (!arm)       state_d = StIdle;
            end
            StDone:   if (!arm) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        elapsed_d      = elapsed_q;
        best_d         = best_q;
        result_valid_d = result_valid_q;
        false_start_d  = false_start_q;
        timeout_d      = timeout_q;
        best_valid_d   = best_valid_q;
        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    elapsed_d      = '0;
                    result_valid_d = 1'b0;
                    false_start_d  = 1'b0;
                    timeout_d      = 1'b0;
                end
            end
            StArmed: begin
                if (press) begin
                    false_start_d  = 1'b1;
                    result_valid_d = 1'b0;
                end else if (go) begin
                    elapsed_d = '0;
                end
            end
            StTiming: begin
                if (press) begin
                    result_valid_d = 1'b1;
                    if (beats_best(32'(elapsed_q), 32'(best_q), best_valid_q)) begin
                        best_d       = elapsed_q;
                        best_valid_d = 1'b1;
                    end
                end else if (at_max) begin
                    timeout_d = 1'b1;
                end else if (!arm) begin
                    elapsed_d = '0;
                end else begin
                    elapsed_d = elapsed_q + CNT_W'(1);
                end
            end
            StDone: ;
            default: ;
        endcase
    end

    assign busy         = (state_q == StArmed) || (state_q == StTiming);
    assign elapsed      = elapsed_q;
    assign result_valid = result_valid_q;
    assign false_start  = false_start_q;
    assign timeout      = timeout_q;
    assign best         = best_q;
    assign best_valid   = best_valid_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Scoreboard bench for reaction_timer: an event-time model predicts each round's outcome,
// a monitor compares it when busy falls.
module tb_reaction_timer;

    localparam int unsigned CNT_W = 14;
    localparam int          MAXC  = 9999;
    localparam int          LIMIT = 10200;
    localparam int          INF   = 1 << 30;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             arm = 1'b0;
    logic             go = 1'b0;
    logic             button = 1'b0;
    logic [CNT_W-1:0] elapsed;
    logic [CNT_W-1:0] best;
    logic             result_valid, false_start, timeout, best_valid, busy;

    reaction_timer #(
        .CNT_W     (CNT_W),
        .MAX_COUNT (MAXC)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .arm          (arm),
        .go           (go),
        .button       (button),
        .elapsed      (elapsed),
        .result_valid (result_valid),
        .false_start  (false_start),
        .timeout      (timeout),
        .best         (best),
        .best_valid   (best_valid),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int elapsed;
        bit rv;
        bit fs;
        bit to;
        int best;
        bit bv;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   best_m = 0;
    bit   bv_m = 1'b0;
    bit   busy_prev = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, "_elapsed"}, int'(elapsed), e.elapsed);
        check({tag, "_result_valid"}, int'(result_valid), int'(e.rv));
        check({tag, "_false_start"}, int'(false_start), int'(e.fs));
        check({tag, "_timeout"}, int'(timeout), int'(e.to));
        check({tag, "_best"}, int'(best), e.best);
        check({tag, "_best_valid"}, int'(best_valid), int'(e.bv));
    endtask

    // Edges are numbered from the one that first samples arm=1 (edge 1, IDLE->ARMED).
    // A button first sampled at edge b produces a press that acts on edge b+2.
    // elapsed after TIMING is entered at edge g reads k-g after edge k.
    function automatic exp_t model_round(input int go_at, input int btn_at, input int abort_at);
        exp_t e;
        int p, a, g, t, a2;
        e.elapsed = 0; e.rv = 0; e.fs = 0; e.to = 0;
        p = (btn_at >= 0) ? btn_at + 2 : INF;
        a = (abort_at >= 0) ? abort_at : INF;
        g = go_at;
        if (p <= g && p <= a) begin
            e.fs = 1;
        end else if (g <= a) begin
            t  = g + MAXC + 1;
            a2 = (a > g) ? a : g + 1;
            if (p <= t && p <= a2) begin
                e.rv      = 1;
                e.elapsed = p - 1 - g;
            end else if (t < a2) begin
                e.to      = 1;
                e.elapsed = MAXC;
            end
        end
        if (e.rv && (!bv_m || e.elapsed < best_m)) begin
            best_m = e.elapsed;
            bv_m   = 1;
        end
        e.best = best_m;
        e.bv   = bv_m;
        return e;
    endfunction

    always @(negedge clock) begin
        if (!reset_n) begin
            busy_prev <= 1'b0;
        end else begin
            check("one_flag_at_most", int'(result_valid) + int'(false_start) + int'(timeout) <= 1
                  ? 1 : 0, 1);
            if (busy_prev && !busy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got a result, expected none (t=%0t)",
                             $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_all("result", mon_e);
                end
            end
            busy_prev <= busy;
        end
    end

    task automatic run_round(input int go_at, input int btn_at, input int abort_at);
        exp_t e;
        int   k;
        bit   done;
        e = model_round(go_at, btn_at, abort_at);
        exp_q.push_back(e);
        if (btn_at == 0) begin
            button = 1'b1;
            @(negedge clock);
        end
        k    = 1;
        done = 1'b0;
        while (!done && k <= LIMIT) begin
            arm    = !(abort_at >= 0 && k >= abort_at);
            go     = (k >= go_at);
            button = (btn_at >= 0 && k >= btn_at);
            @(posedge clock);
            @(negedge clock);
            if (!busy) done = 1'b1;
            k++;
        end
        check("round_finished", int'(done), 1);
        if (e.rv || e.fs || e.to) begin
            arm = 1'b1;
            go  = 1'b1;
            repeat (100) @(negedge clock);
            check_all("done_hold", e);
            check("done_busy", int'(busy), 0);
            button = 1'b0;
            repeat (4) @(negedge clock);
            button = 1'b1;
            repeat (6) @(negedge clock);
            check_all("repress", e);
        end
        arm    = 1'b0;
        go     = 1'b0;
        button = 1'b0;
        repeat (6) @(negedge clock);
        check_all("idle_hold", e);
        check("idle_busy", int'(busy), 0);
    endtask

    initial begin
        int g, b, a, kind;
        #1;
        check("rst_elapsed", int'(elapsed), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_best_valid", int'(best_valid), 0);
        check("rst_flags", int'(result_valid) + int'(false_start) + int'(timeout), 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        run_round(20, 270, -1);           // normal round
        run_round(40, 10, -1);            // false start, go ignored afterwards
        run_round(20, 300 + 19, -1);      // best tracking 300, 180, 180, 400
        run_round(20, 180 + 19, -1);
        run_round(20, 180 + 19, -1);
        run_round(20, 400 + 19, -1);
        run_round(30, 0, -1);             // button held from before arm
        run_round(5, -1, -1);             // timeout
        run_round(5, 5 + MAXC - 1, -1);   // press as elapsed sits at MAX_COUNT
        run_round(50, -1, 30);            // abort in ARMED
        run_round(10, -1, 100);           // abort in TIMING
        run_round(30, 28, -1);            // press and go on the same edge
        run_round(30, -1, 30);            // go and arm drop on the same edge

        for (int i = 0; i < 12; i++) begin
            g    = int'($urandom_range(2, 60));
            kind = int'($urandom_range(0, 3));
            b    = g + int'($urandom_range(0, 500)) - 3;
            if (b < 1) b = 1;
            a = (kind == 0) ? int'($urandom_range(2, 400)) : -1;
            run_round(g, b, a);
        end

        // Asynchronous reset in the middle of TIMING.
        arm = 1'b1;
        go  = 1'b1;
        repeat (59) @(posedge clock);
        @(negedge clock);
        check("pre_reset_elapsed", int'(elapsed), 57);
        #2 reset_n = 1'b0;
        #1;
        check("arst_elapsed", int'(elapsed), 0);
        check("arst_best", int'(best), 0);
        check("arst_best_valid", int'(best_valid), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_flags", int'(result_valid) + int'(false_start) + int'(timeout), 0);
        best_m = 0;
        bv_m   = 1'b0;
        arm    = 1'b0;
        go     = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_elapsed", int'(elapsed), 0);

        run_round(15, 15 + 120, -1);

        repeat (3) @(negedge clock);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
